div_iter: RTL

- Iterative radix-2 restoring divider; inverse of the Booth/Wallace multiplier in the RV32IM execute stage.
- Serves DIV/DIVU/REM/REMU with RISC-V M-extension special-case semantics.
- Multi-cycle unit; the pipeline stalls on the valid/ready handshakes.
- Returns quotient and remainder together; the caller selects which one to use.

---
 rtl/div_iter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_EARLY_OUT_EN to finish |x| < |y| requests in one cycle.
module div_iter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic         i_x_sign,
    input  logic         i_y_sign,
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_quot,
    output logic [W-1:0] o_rem
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    ymag_q, ymag_d;
    logic [W-1:0]    oq_q, oq_d;
    logic [W-1:0]    or_q, or_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            x_neg, y_neg, div_zero, ovf, early;
    logic [W-1:0]    x_mag, y_mag;
    logic [W:0]      shifted, trial;
    logic [W-1:0]    q_next, r_next;

    assign x_neg    = i_x_sign & i_x[W-1];
    assign y_neg    = i_y_sign & i_y[W-1];
    assign x_mag    = x_neg ? -i_x : i_x;
    assign y_mag    = y_neg ? -i_y : i_y;
    assign div_zero = (i_y == '0);
    assign ovf      = i_x_sign & i_y_sign & (i_x == {1'b1, {(W-1){1'b0}}}) & (i_y == '1);

`ifdef DIV_EARLY_OUT_EN
    assign early = (x_mag < y_mag);
`else
    assign early = 1'b0;
`endif

    // One restoring step: the borrow out of the W+1-bit trial decides the quotient bit.
    assign shifted = {rem_q, quot_q[W-1]};
    assign trial   = shifted - {1'b0, ymag_q};
    assign q_next  = {quot_q[W-2:0], ~trial[W]};
    assign r_next  = trial[W] ? shifted[W-1:0] : trial[W-1:0];

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_quot  = oq_q;
    assign o_rem   = or_q;

    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        ymag_d  = ymag_q;
        oq_d    = oq_q;
        or_d    = or_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        qneg_d = x_neg ^ y_neg;
                        rneg_d = x_neg;
                        ymag_d = y_mag;
                        if (div_zero) begin
                            oq_d    = '1;
                            or_d    = i_x;
                            state_d = DONE;
                        end else if (ovf) begin
                            oq_d    = {1'b1, {(W-1){1'b0}}};
                            or_d    = '0;
                            state_d = DONE;
                        end else if (early) begin
                            oq_d    = '0;
                            or_d    = i_x;
                            state_d = DONE;
                        end else begin
                            rem_d   = '0;
                            quot_d  = x_mag;
                            cnt_d   = '0;
                            state_d = CALC;
                        end
                    end
                end
                CALC: begin
                    quot_d = q_next;
                    rem_d  = r_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        oq_d    = qneg_q ? -q_next : q_next;
                        or_d    = rneg_q ? -r_next : r_next;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (i_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            ymag_q  <= '0;
            oq_q    <= '0;
            or_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            ymag_q  <= ymag_d;
            oq_q    <= oq_d;
            or_q    <= or_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
